// File: rtl/cei_mochila_pkg.sv
// rtl/cei_mochila_pkg.sv - platform constants and TMR hart-monitor types
package cei_mochila_pkg;

  localparam int TMR_NHARTS = 3;

  typedef enum logic [1:0] {
    HART_HEALTHY = 2'd0,
    HART_SUSPECT = 2'd1,
    HART_FAULTY  = 2'd2
  } hart_state_e;

  function automatic logic [1:0] count_ones3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request type shared by cores and voter
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/tmr_hart_monitor.sv
// rtl/tmr_hart_monitor.sv - per-hart HEALTHY/SUSPECT/FAULTY tracker with
// consecutive and saturating total mismatch counters
module tmr_hart_monitor
  import cei_mochila_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             mismatch_i,
  output logic             fault_o,
  output logic             fault_next_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [7:0] THRESH_C = 8'(THRESH);

  hart_state_e      r_state, w_state_nxt;
  logic [7:0]       r_consec, w_consec_nxt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state  <= HART_HEALTHY;
      r_consec <= 8'd0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_consec <= w_consec_nxt;
      if (enable_i && mismatch_i && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // consec cannot overflow: SUSPECT is only held while consec < THRESH <= 255
  always_comb begin
    w_state_nxt  = r_state;
    w_consec_nxt = r_consec;
    if (enable_i) begin
      case (r_state)
        HART_HEALTHY: begin
          if (mismatch_i) begin
            w_consec_nxt = 8'd1;
            w_state_nxt  = (THRESH_C == 8'd1) ? HART_FAULTY : HART_SUSPECT;
          end
        end
        HART_SUSPECT: begin
          if (mismatch_i) begin
            w_consec_nxt = r_consec + 8'd1;
            if ((r_consec + 8'd1) >= THRESH_C)
              w_state_nxt = HART_FAULTY;
          end else begin
            w_consec_nxt = 8'd0;
            w_state_nxt  = HART_HEALTHY;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fault_o      = (r_state == HART_FAULTY);
    fault_next_o = (w_state_nxt == HART_FAULTY);
    cnt_o        = r_cnt;
  end

endmodule

// File: rtl/tmr_voter_monitor.sv
// rtl/tmr_voter_monitor.sv - TMR OBI request voter with per-hart fault
// tracking, degraded-mode selection and fatal/irq reporting
module tmr_voter_monitor
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS = TMR_NHARTS,
  parameter int NCHAN  = 2,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              clear_i,
  input  obi_req_t          core_req_i     [NCHAN][NHARTS],
  output obi_req_t          voted_req_o    [NCHAN],
  output logic [NHARTS-1:0] mismatch_o,
  output logic [NHARTS-1:0] fault_id_o,
  output logic              degraded_o,
  output logic              fatal_o,
  output logic              irq_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o [NHARTS]
);

  if (NHARTS != TMR_NHARTS) begin : g_bad_nharts
    $error("tmr_voter_monitor: NHARTS must be 3");
  end
  if (THRESH < 1 || THRESH > 255) begin : g_bad_thresh
    $error("tmr_voter_monitor: THRESH must be in 1..255");
  end

  logic [NHARTS-1:0] w_fault, w_fault_nxt, w_raw_mm, w_mismatch;
  logic [1:0]        w_nfault, w_sel;
  logic              w_fatal_set;
  obi_req_t          w_voted [NCHAN];
  logic              r_fatal, r_irq, r_degraded;

  assign w_nfault = count_ones3(w_fault);

  always_comb begin
    w_sel = 2'd0;
    for (int h = NHARTS - 1; h >= 0; h--)
      if (!w_fault[h]) w_sel = 2'(h);
  end

  // Full bitwise majority while all harts are trusted; otherwise follow a survivor
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      if (w_nfault == 2'd0)
        w_voted[c] = obi_req_t'((core_req_i[c][0] & core_req_i[c][1]) |
                                (core_req_i[c][1] & core_req_i[c][2]) |
                                (core_req_i[c][0] & core_req_i[c][2]));
      else
        w_voted[c] = core_req_i[c][w_sel];
    end
  end

  always_comb begin
    w_raw_mm = '0;
    for (int c = 0; c < NCHAN; c++) begin
      for (int h = 0; h < NHARTS; h++) begin
        if ((core_req_i[c][h].req && (core_req_i[c][h].addr  != w_voted[c].addr))  ||
            (core_req_i[c][h].we  && (core_req_i[c][h].wdata != w_voted[c].wdata)) ||
            (core_req_i[c][h].be  != w_voted[c].be) ||
            (core_req_i[c][h].we  != w_voted[c].we) ||
            (core_req_i[c][h].req != w_voted[c].req))
          w_raw_mm[h] = 1'b1;
      end
    end
  end

  assign w_mismatch = w_raw_mm & {NHARTS{enable_i}};

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    tmr_hart_monitor #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
    ) u_mon (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i),
      .clear_i      (clear_i),
      .mismatch_i   (w_mismatch[h]),
      .fault_o      (w_fault[h]),
      .fault_next_o (w_fault_nxt[h]),
      .cnt_o        (mismatch_cnt_o[h])
    );
  end

  // In degraded mode the selected survivor never mismatches itself, so any
  // non-faulty mismatch is a disagreement between the two survivors
  assign w_fatal_set = enable_i &&
                       (((w_nfault == 2'd1) && |(w_mismatch & ~w_fault)) ||
                        (w_nfault >= 2'd2));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_fatal    <= 1'b0;
      r_irq      <= 1'b0;
      r_degraded <= 1'b0;
    end else begin
      r_fatal    <= r_fatal | w_fatal_set;
      r_irq      <= (|(w_fault_nxt & ~w_fault)) | (w_fatal_set & ~r_fatal);
      r_degraded <= (count_ones3(w_fault_nxt) == 2'd1);
    end
  end

  assign voted_req_o = w_voted;
  assign mismatch_o  = w_mismatch;
  assign fault_id_o  = w_fault;
  assign degraded_o  = r_degraded;
  assign fatal_o     = r_fatal;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// tb/tb_tmr_voter_monitor.sv - self-checking bench for tmr_voter_monitor
module tb_tmr_voter_monitor;
  import obi_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n, enable, clear;
  obi_req_t req   [2][3];
  obi_req_t voted [2];
  obi_req_t voted1[2];
  logic [2:0] mm, fid, mm1, fid1;
  logic       degr, fatal, irq, degr1, fatal1, irq1;
  logic [7:0] cnt  [3];
  logic [1:0] cnt1 [3];

  int n_tests = 0;
  int n_fail  = 0;
  int irq_cnt;

  always #5 clk = ~clk;

  tmr_voter_monitor u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .core_req_i(req), .voted_req_o(voted), .mismatch_o(mm), .fault_id_o(fid),
    .degraded_o(degr), .fatal_o(fatal), .irq_o(irq), .mismatch_cnt_o(cnt)
  );

  tmr_voter_monitor #(.THRESH(1), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .core_req_i(req), .voted_req_o(voted1), .mismatch_o(mm1), .fault_id_o(fid1),
    .degraded_o(degr1), .fatal_o(fatal1), .irq_o(irq1), .mismatch_cnt_o(cnt1)
  );

  typedef struct {
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][3:0]  be;
    logic [2:0]       we;
    logic [2:0]       rq;
    logic [31:0]      e_addr;
    logic [31:0]      e_wdata;
    logic [3:0]       e_be;
    logic             e_we;
    logic [2:0]       e_mm;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, w0, w1, w2,
                              input logic [3:0] b0, b1, b2,
                              input logic [2:0] we, rq,
                              input logic [31:0] ea, ew,
                              input logic [3:0] eb, input logic ewe,
                              input logic [2:0] emm);
    vec_t v;
    v.addr[0] = a0;  v.addr[1] = a1;  v.addr[2] = a2;
    v.wdata[0] = w0; v.wdata[1] = w1; v.wdata[2] = w2;
    v.be[0] = b0;    v.be[1] = b1;    v.be[2] = b2;
    v.we = we; v.rq = rq;
    v.e_addr = ea; v.e_wdata = ew; v.e_be = eb; v.e_we = ewe; v.e_mm = emm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base();
    for (int c = 0; c < 2; c++)
      for (int h = 0; h < 3; h++) begin
        req[c][h].req   = 1'b1;
        req[c][h].we    = 1'b0;
        req[c][h].be    = 4'hF;
        req[c][h].addr  = (c == 0) ? 32'h80 : 32'h1000;
        req[c][h].wdata = 32'h0;
      end
  endtask

  // Hart 2 drives a different instr wdata with we=1 for THRESH cycles
  task automatic fault_hart2();
    for (int h = 0; h < 3; h++) req[0][h].we = 1'b1;
    req[0][0].wdata = 32'hAA;
    req[0][1].wdata = 32'hAA;
    req[0][2].wdata = 32'h55;
    irq_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      irq_cnt += int'(irq);
      if (k < 3) chk("h2_not_yet_faulty", fid, 3'b000);
    end
  endtask

  initial begin
    //       a0        a1        a2        w0     w1     w2     b0    b1    b2    we      rq      e_addr    e_wdata e_be  e_we  e_mm
    vt[0] = mk(32'h1000, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b000, 3'b111, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b000);
    vt[1] = mk(32'h1000, 32'h2000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b000, 3'b111, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b010);
    vt[2] = mk(32'hDEAD, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b000, 3'b000, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b000);
    vt[3] = mk(32'h0F0F, 32'h00FF, 32'hF000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b000, 3'b111, 32'h000F, 32'h0,  4'hF, 1'b0, 3'b111);
    vt[4] = mk(32'h1000, 32'h1000, 32'h1000, 32'h11, 32'h11, 32'h22, 4'hF, 4'hF, 4'hF, 3'b111, 3'b111, 32'h1000, 32'h11, 4'hF, 1'b1, 3'b100);
    vt[5] = mk(32'h1000, 32'h1000, 32'h1000, 32'h11, 32'h11, 32'h22, 4'hF, 4'hF, 4'hF, 3'b000, 3'b111, 32'h1000, 32'h11, 4'hF, 1'b0, 3'b000);
    vt[6] = mk(32'h1000, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'h1, 4'hF, 4'hF, 3'b000, 3'b111, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b001);
    vt[7] = mk(32'h1000, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b010, 3'b111, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b010);
    vt[8] = mk(32'h1000, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'h3, 4'h5, 4'h6, 3'b000, 3'b111, 32'h1000, 32'h0,  4'h7, 1'b0, 3'b111);
    vt[9] = mk(32'h1000, 32'h1000, 32'h1000, 32'h0,  32'h0,  32'h0,  4'hF, 4'hF, 4'hF, 3'b000, 3'b110, 32'h1000, 32'h0,  4'hF, 1'b0, 3'b001);

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
    set_base();
    tick(); tick();
    chk("rst_fault_id", fid, 3'b000);
    chk("rst_degraded", degr, 1'b0);
    chk("rst_fatal", fatal, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cnt1", cnt[1], 8'd0);
    rst_n = 1'b1;
    tick();

    // Combinational vote table; each vector is followed by a clear edge
    for (int i = 0; i < 10; i++) begin
      for (int h = 0; h < 3; h++) begin
        req[1][h].addr  = vt[i].addr[h];
        req[1][h].wdata = vt[i].wdata[h];
        req[1][h].be    = vt[i].be[h];
        req[1][h].we    = vt[i].we[h];
        req[1][h].req   = vt[i].rq[h];
      end
      #1;
      chk($sformatf("v%0d_addr", i), voted[1].addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), voted[1].wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_be", i), voted[1].be, vt[i].e_be);
      chk($sformatf("v%0d_we", i), voted[1].we, vt[i].e_we);
      chk($sformatf("v%0d_mm", i), mm, vt[i].e_mm);
      chk($sformatf("v%0d_instr_addr", i), voted[0].addr, 32'h80);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk($sformatf("v%0d_clr_irq", i), irq, 1'b0);
      chk($sformatf("v%0d_clr_cnt", i), cnt[1], 8'd0);
      set_base();
    end

    // Three-cycle transient on hart 1 recovers without faulting
    irq_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        req[1][1].addr = 32'h2000;
        tick();
        irq_cnt += int'(irq);
      end
      req[1][1].addr = 32'h1000;
      tick();
      irq_cnt += int'(irq);
      chk($sformatf("transient%0d_cnt1", r), cnt[1], (r == 0) ? 8'd3 : 8'd6);
      chk($sformatf("transient%0d_fault", r), fid, 3'b000);
    end
    chk("transient_irq_count", irq_cnt, 0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Hart 2 faults after THRESH cycles; single irq
    fault_hart2();
    chk("h2_fault_id", fid, 3'b100);
    chk("h2_degraded", degr, 1'b1);
    chk("h2_irq_high", irq, 1'b1);
    tick();
    irq_cnt += int'(irq);
    chk("h2_irq_pulses", irq_cnt, 1);
    set_base();
    req[1][1].addr = 32'h3000;
    req[1][2].addr = 32'h3000;
    #1;
    chk("degr_follows_h0", voted[1].addr, 32'h1000);
    chk("degr_mm", mm, 3'b110);
    set_base();

    // Survivors disagree -> fatal
    req[1][1].be = 4'h3;
    tick();
    chk("fatal_set", fatal, 1'b1);
    chk("fatal_irq", irq, 1'b1);
    set_base();
    tick();
    chk("fatal_irq_once", irq, 1'b0);
    chk("fatal_sticky", fatal, 1'b1);
    chk("fatal_degr", degr, 1'b1);

    // Disabled: state frozen, voting keeps using the FAULTY mask
    enable = 1'b0;
    req[1][1].addr = 32'h5000;
    #1;
    chk("dis_mm", mm, 3'b000);
    chk("dis_vote", voted[1].addr, 32'h1000);
    for (int k = 0; k < 5; k++) tick();
    chk("dis_cnt1", cnt[1], 8'd1);
    chk("dis_fault", fid, 3'b100);
    chk("dis_fatal", fatal, 1'b1);
    enable = 1'b1;

    // Clear beats same-cycle mismatch
    req[1][1].addr = 32'h2000;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_base();
    chk("clr_fault", fid, 3'b000);
    chk("clr_degr", degr, 1'b0);
    chk("clr_fatal", fatal, 1'b0);
    chk("clr_irq", irq, 1'b0);
    chk("clr_cnt1", cnt[1], 8'd0);
    chk("clr_cnt2", cnt[2], 8'd0);

    // Reset while FAULTY beats clear and enable
    fault_hart2();
    chk("pre_rst_fault", fid, 3'b100);
    rst_n = 1'b0;
    clear = 1'b1;
    tick();
    chk("midrst_fault", fid, 3'b000);
    chk("midrst_degr", degr, 1'b0);
    chk("midrst_fatal", fatal, 1'b0);
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_cnt2", cnt[2], 8'd0);
    rst_n = 1'b1;
    clear = 1'b0;
    set_base();
    tick();

    // THRESH=1 faults immediately; counters saturate
    req[1][1].addr = 32'h2000;
    tick();
    chk("t1_fault", fid1, 3'b010);
    chk("t1_irq", irq1, 1'b1);
    chk("t4_not_fault", fid, 3'b000);
    for (int k = 0; k < 259; k++) tick();
    chk("sat_cnt1", cnt[1], 8'd255);
    chk("sat_cnt0", cnt[0], 8'd0);
    chk("sat_fault", fid, 3'b010);
    chk("sat_fatal", fatal, 1'b0);
    chk("sat_t1_cnt1", cnt1[1], 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
